decode_stage: RTL

Registered, handshaked RV32 instruction-decode pipeline stage with parametrised PC width and address granularity. Accepts fetched instruction/PC pairs on a valid/ready interface and presents decoded fields one cycle later. Also provides fully sign-extended immediates, PC-relative branch/JAL targets with misalignment detection, illegal-opcode flagging, flush, and decode/illegal event counters. Sits between fetch and execute; JALR targets stay in execute because they need rs1 data.

---
 rtl/decode_pkg.sv | 41 ++++
 rtl/decode_imm_gen.sv | 41 ++++
 rtl/decode_stage.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared types and constants for the RV32 decode stage.
//   inst_type_e     - 3-bit instruction class presented on decode_stage.inst_type
//   OPC_*           - RV32 major opcodes recognised by the decoder
//   opcode_to_type  - maps a 7-bit major opcode to its instruction class
package decode_pkg;

  typedef enum logic [2:0] {
    IT_R       = 3'd0,
    IT_I       = 3'd1,
    IT_U       = 3'd2,
    IT_CSR     = 3'd3,
    IT_B       = 3'd4,
    IT_JAL     = 3'd5,
    IT_JALR    = 3'd6,
    IT_ILLEGAL = 3'd7
  } inst_type_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  function automatic inst_type_e opcode_to_type(input logic [6:0] opc);
    inst_type_e t;
    case (opc)
      OPC_OP:     t = IT_R;
      OPC_OP_IMM: t = IT_I;
      OPC_LUI:    t = IT_U;
      OPC_SYSTEM: t = IT_CSR;
      OPC_BRANCH: t = IT_B;
      OPC_JAL:    t = IT_JAL;
      OPC_JALR:   t = IT_JALR;
      default:    t = IT_ILLEGAL;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/decode_imm_gen.sv
// imm_gen: combinational classifier and immediate generator.
//   inst       in  32   : raw instruction word
//   inst_type  out enum : instruction class
//   imm        out XLEN : sign-extended immediate for that class (0 for R/ILLEGAL)
//   misaligned out 1    : B/JAL offset not a multiple of 4 when the PC counts words
module imm_gen
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_WORD = 1
) (
  input  logic [31:0]     inst,
  output inst_type_e      inst_type,
  output logic [XLEN-1:0] imm,
  output logic            misaligned
);

  logic [31:0] imm32;

  always_comb begin
    inst_type = opcode_to_type(inst[6:0]);
    imm32     = '0;
    case (inst_type)
      IT_I, IT_JALR, IT_CSR: imm32 = {{20{inst[31]}}, inst[31:20]};
      IT_U:                  imm32 = {inst[31:12], 12'b0};
      IT_B:                  imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                                      inst[11:8], 1'b0};
      IT_JAL:                imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                                      inst[30:21], 1'b0};
      default:               imm32 = '0;
    endcase
  end

  // Widening a signed value sign-extends for XLEN > 32.
  assign imm = XLEN'($signed(imm32));

  // B/JAL offsets are even by construction; with a word-granular PC only bit 1 can
  // make the offset unrepresentable.
  assign misaligned = (inst_type == IT_B || inst_type == IT_JAL) && (PC_WORD != 0) && imm32[1];

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, valid/ready RV32 decode stage.
//   clk, rst_n (async, active low), flush (sync kill of held + incoming instruction)
//   in_valid/in_ready, inst, pc          : from fetch
//   out_valid/out_ready, out_pc          : to execute
//   opcode, funct3, funct7, rd, rs1, rs2, csr : raw fields of the held instruction
//   inst_type, imm, target, misaligned, illegal : decoded information
//   decoded_cnt (wraps), illegal_cnt (saturates) : event counters
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PC_W    = 12,
  parameter int PC_WORD = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [PC_W-1:0]  pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [6:0]       opcode,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [11:0]      csr,
  output logic [2:0]       inst_type,
  output logic [XLEN-1:0]  imm,
  output logic [PC_W-1:0]  target,
  output logic             misaligned,
  output logic             illegal,
  output logic [CNT_W-1:0] decoded_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  inst_type_e      dec_type;
  logic [XLEN-1:0] dec_imm;
  logic            dec_mis;
  logic [PC_W-1:0] off_pc;
  logic [PC_W-1:0] dec_target;
  logic            accept;

  logic             valid_q,  valid_d;
  logic [PC_W-1:0]  pc_q,     pc_d;
  logic [31:0]      inst_q,   inst_d;
  inst_type_e       type_q,   type_d;
  logic [XLEN-1:0]  imm_q,    imm_d;
  logic [PC_W-1:0]  target_q, target_d;
  logic             mis_q,    mis_d;
  logic [CNT_W-1:0] dcnt_q,   dcnt_d;
  logic [CNT_W-1:0] icnt_q,   icnt_d;

  imm_gen #(
    .XLEN    (XLEN),
    .PC_WORD (PC_WORD)
  ) u_imm_gen (
    .inst       (inst),
    .inst_type  (dec_type),
    .imm        (dec_imm),
    .misaligned (dec_mis)
  );

  // Offset in PC units, truncated/sign-extended to PC_W; the add wraps modulo 2^PC_W.
  assign off_pc = (PC_WORD != 0) ? PC_W'($signed(dec_imm) >>> 2) : PC_W'($signed(dec_imm));

  assign dec_target = (dec_type == IT_B || dec_type == IT_JAL) ? (pc + off_pc) : '0;

  // Single register stage: a slot frees up in the same cycle execute takes the bundle.
  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    inst_d   = inst_q;
    type_d   = type_q;
    imm_d    = imm_q;
    target_d = target_q;
    mis_d    = mis_q;
    dcnt_d   = dcnt_q;
    icnt_d   = icnt_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d  = 1'b1;
      pc_d     = pc;
      inst_d   = inst;
      type_d   = dec_type;
      imm_d    = dec_imm;
      target_d = dec_target;
      mis_d    = dec_mis;
      dcnt_d   = dcnt_q + 1'b1;
      if (dec_type == IT_ILLEGAL && icnt_q != '1) begin
        icnt_d = icnt_q + 1'b1;
      end
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      pc_q     <= '0;
      inst_q   <= '0;
      type_q   <= IT_R;
      imm_q    <= '0;
      target_q <= '0;
      mis_q    <= 1'b0;
      dcnt_q   <= '0;
      icnt_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      type_q   <= type_d;
      imm_q    <= imm_d;
      target_q <= target_d;
      mis_q    <= mis_d;
      dcnt_q   <= dcnt_d;
      icnt_q   <= icnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_pc      = pc_q;
  assign opcode      = inst_q[6:0];
  assign rd          = inst_q[11:7];
  assign funct3      = inst_q[14:12];
  assign rs1         = inst_q[19:15];
  assign rs2         = inst_q[24:20];
  assign funct7      = inst_q[31:25];
  assign csr         = inst_q[31:20];
  assign inst_type   = type_q;
  assign imm         = imm_q;
  assign target      = target_q;
  assign misaligned  = mis_q;
  assign illegal     = (type_q == IT_ILLEGAL);
  assign decoded_cnt = dcnt_q;
  assign illegal_cnt = icnt_q;

endmodule
